// File: rtl/charger_pkg.sv
// Shared charger definitions: controller state set, key codes, amount limit
// and a binary-to-BCD helper for the two-digit display.
package charger_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ENTRY    = 2'd1,
      LOCKED   = 2'd2,
      CHARGING = 2'd3
   } charger_state_e;

   localparam logic [3:0] KEY_0 = 4'd0;
   localparam logic [3:0] KEY_1 = 4'd1;
   localparam logic [3:0] KEY_2 = 4'd2;
   localparam logic [3:0] KEY_3 = 4'd3;
   localparam logic [3:0] KEY_4 = 4'd4;
   localparam logic [3:0] KEY_5 = 4'd5;
   localparam logic [3:0] KEY_6 = 4'd6;
   localparam logic [3:0] KEY_7 = 4'd7;
   localparam logic [3:0] KEY_8 = 4'd8;
   localparam logic [3:0] KEY_9 = 4'd9;

   localparam int unsigned MAX_AMOUNT_DEF = 20;

   // Amounts never exceed 99, so tens and ones each fit a nibble.
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

endpackage

// File: rtl/amount_entry_manager_if.sv
// Key-event inputs from the scanner and amount/handshake outputs towards the
// charge controller, bundled for the amount entry manager.
interface amount_entry_manager_if;

   logic [3:0] key_value;
   logic       press_num;
   logic       start;
   logic       clear;
   logic       confirm;
   logic       charge_done;

   logic [6:0] amount_bin;
   logic [7:0] amount_bcd;
   logic [1:0] digit_cnt;
   logic       amount_valid;
   logic       start_req;
   logic       entry_err;
   logic       timeout;

   modport master (
      output key_value, press_num, start, clear, confirm, charge_done,
      input  amount_bin, amount_bcd, digit_cnt, amount_valid,
             start_req, entry_err, timeout
   );

   modport slave (
      input  key_value, press_num, start, clear, confirm, charge_done,
      output amount_bin, amount_bcd, digit_cnt, amount_valid,
             start_req, entry_err, timeout
   );

endinterface

// File: rtl/key_edge_detect.sv
// 4-bit rising-edge detector; history resets high so keys held across reset
// release never register as a press.
module key_edge_detect (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_level,
   output logic [3:0] o_rise
);

   logic [3:0] r_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_prev <= '1;
      else       r_prev <= i_level;
   end

   assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/amount_entry_manager.sv
// Turns scanner key events into a validated charge amount and start request.
// Optional idle auto-clear is built only when AMOUNT_ENTRY_TIMEOUT_EN is defined.
module amount_entry_manager
   import charger_pkg::*;
#(
   parameter int unsigned MAX_DIGITS  = 2,
   parameter int unsigned MAX_AMOUNT  = MAX_AMOUNT_DEF,
   parameter int unsigned TIMEOUT_CYC = 10000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   amount_entry_manager_if.slave bus
);

   localparam logic [1:0] S_IDLE     = IDLE;
   localparam logic [1:0] S_ENTRY    = ENTRY;
   localparam logic [1:0] S_LOCKED   = LOCKED;
   localparam logic [1:0] S_CHARGING = CHARGING;

   localparam logic [1:0] MAX_DIG = 2'(MAX_DIGITS);
   localparam logic [7:0] MAX_AMT = 8'(MAX_AMOUNT);

   logic [3:0] w_rise;
   logic       w_ev_num, w_ev_start, w_ev_clr, w_ev_cfm, w_any_ev;
   logic [7:0] w_cand;
   logic       w_to_fire;

   logic [1:0] r_state, w_state_n;
   logic [6:0] r_amount, w_amount_n;
   logic [7:0] r_bcd;
   logic [1:0] r_cnt, w_cnt_n;
   logic       r_valid;
   logic       r_req, w_req_n;
   logic       r_err, w_err_n;

   key_edge_detect u_key_edge (
      .i_clk   (clk),
      .i_rst   (rst_n),
      .i_level ({bus.press_num, bus.start, bus.clear, bus.confirm}),
      .o_rise  (w_rise)
   );

   assign {w_ev_num, w_ev_start, w_ev_clr, w_ev_cfm} = w_rise;
   assign w_any_ev = |w_rise;
   assign w_cand   = ({1'b0, r_amount} * 8'd10) + {4'b0000, bus.key_value};

   // One case arm per state; inside each arm the if-chain order encodes
   // the clear > confirm > start > digit priority.
   always_comb begin
      w_state_n  = r_state;
      w_amount_n = r_amount;
      w_cnt_n    = r_cnt;
      w_req_n    = 1'b0;
      w_err_n    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_ev_clr) begin
               if (w_ev_cfm || w_ev_start) begin
                  w_err_n = 1'b1;
               end else if (w_ev_num && bus.key_value != KEY_0) begin
                  if ({4'b0000, bus.key_value} > MAX_AMT) begin
                     w_err_n = 1'b1;
                  end else begin
                     w_amount_n = {3'b000, bus.key_value};
                     w_cnt_n    = 2'd1;
                     w_state_n  = S_ENTRY;
                  end
               end
            end
         end
         S_ENTRY: begin
            if (w_ev_clr) begin
               w_state_n  = S_IDLE;
               w_amount_n = '0;
               w_cnt_n    = '0;
            end else if (w_ev_cfm) begin
               w_state_n = S_LOCKED;
            end else if (w_ev_start) begin
               w_err_n = 1'b1;
            end else if (w_ev_num) begin
               if (r_cnt == MAX_DIG || w_cand > MAX_AMT) begin
                  w_err_n = 1'b1;
               end else begin
                  w_amount_n = w_cand[6:0];
                  w_cnt_n    = r_cnt + 2'd1;
               end
            end
         end
         S_LOCKED: begin
            if (w_ev_clr) begin
               w_state_n  = S_IDLE;
               w_amount_n = '0;
               w_cnt_n    = '0;
            end else if (w_ev_cfm) begin
               w_err_n = 1'b1;
            end else if (w_ev_start) begin
               w_req_n   = 1'b1;
               w_state_n = S_CHARGING;
            end else if (w_ev_num) begin
               w_err_n = 1'b1;
            end
         end
         S_CHARGING: begin
            if (bus.charge_done) begin
               w_state_n  = S_IDLE;
               w_amount_n = '0;
               w_cnt_n    = '0;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
      if (w_to_fire) begin
         w_state_n  = S_IDLE;
         w_amount_n = '0;
         w_cnt_n    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state  <= S_IDLE;
         r_amount <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_valid  <= 1'b0;
         r_req    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_amount <= w_amount_n;
         r_bcd    <= to_bcd(w_amount_n);
         r_cnt    <= w_cnt_n;
         r_valid  <= (w_state_n == S_LOCKED) || (w_state_n == S_CHARGING);
         r_req    <= w_req_n;
         r_err    <= w_err_n;
      end
   end

`ifdef AMOUNT_ENTRY_TIMEOUT_EN
   localparam int unsigned   TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] r_tcnt;
   logic          r_timeout;

   // No key event in ENTRY/LOCKED means nothing else can move the state,
   // so the override in the next-state logic never masks another transition.
   assign w_to_fire = (r_state == S_ENTRY || r_state == S_LOCKED) &&
                      !w_any_ev && (r_tcnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_tcnt    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_to_fire;
         if (w_any_ev || (w_state_n != r_state) ||
             !(r_state == S_ENTRY || r_state == S_LOCKED))
            r_tcnt <= '0;
         else
            r_tcnt <= r_tcnt + TW'(1);
      end
   end

   assign bus.timeout = r_timeout;
`else
   logic w_unused_timeout_cfg;

   assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0) && w_any_ev;
   assign w_to_fire            = 1'b0;
   assign bus.timeout          = 1'b0;
`endif

   assign bus.amount_bin   = r_amount;
   assign bus.amount_bcd   = r_bcd;
   assign bus.digit_cnt    = r_cnt;
   assign bus.amount_valid = r_valid;
   assign bus.start_req    = r_req;
   assign bus.entry_err    = r_err;

endmodule

// File: tb/tb_amount_entry_manager.sv
// Directed bench for amount_entry_manager: an integer-level model is checked
// against the DUT every cycle, plus literal expectations per scenario.
module tb_amount_entry_manager;

   localparam int TB_MAXD = 2;
   localparam int TB_MAXA = 20;
   localparam int TB_TO   = 50;

   localparam int PH_IDLE  = 0;
   localparam int PH_ENTRY = 1;
   localparam int PH_LOCK  = 2;
   localparam int PH_CHG   = 3;

   logic clk = 1'b0;
   logic rst_n;

   amount_entry_manager_if bus ();

   amount_entry_manager #(
      .MAX_DIGITS  (TB_MAXD),
      .MAX_AMOUNT  (TB_MAXA),
      .TIMEOUT_CYC (TB_TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;
   int n_req = 0, n_err = 0, n_to = 0;

   int m_amt = 0, m_cnt = 0, m_ph = PH_IDLE, m_quiet = 0;
   bit m_req = 0, m_err = 0, m_to = 0;
   bit p_num = 1, p_st = 1, p_clr = 1, p_cf = 1;

   // Behavioural model: amounts as plain integers, keys as rising edges.
   always @(posedge clk) begin : model
      bit e_num, e_st, e_clr, e_cf, any_ev;
      int old_ph, nv;
      if (rst_n) begin
         m_ph = PH_IDLE; m_amt = 0; m_cnt = 0; m_quiet = 0;
         m_req = 0; m_err = 0; m_to = 0;
         p_num = 1; p_st = 1; p_clr = 1; p_cf = 1;
      end else begin
         e_num = bus.press_num && !p_num;
         e_st  = bus.start     && !p_st;
         e_clr = bus.clear     && !p_clr;
         e_cf  = bus.confirm   && !p_cf;
         p_num = bus.press_num; p_st = bus.start; p_clr = bus.clear; p_cf = bus.confirm;
         any_ev = e_num || e_st || e_clr || e_cf;
         m_req = 0; m_err = 0; m_to = 0;
         old_ph = m_ph;
         if (m_ph == PH_CHG) begin
            if (bus.charge_done) begin m_ph = PH_IDLE; m_amt = 0; m_cnt = 0; end
         end else if (e_clr) begin
            m_ph = PH_IDLE; m_amt = 0; m_cnt = 0;
         end else if (e_cf) begin
            if (m_ph == PH_ENTRY) m_ph = PH_LOCK; else m_err = 1;
         end else if (e_st) begin
            if (m_ph == PH_LOCK) begin m_req = 1; m_ph = PH_CHG; end
            else m_err = 1;
         end else if (e_num) begin
            nv = m_amt * 10 + int'(bus.key_value);
            if (m_ph == PH_LOCK) m_err = 1;
            else if (nv != 0) begin
               if (m_cnt >= TB_MAXD || nv > TB_MAXA) m_err = 1;
               else begin m_amt = nv; m_cnt++; m_ph = PH_ENTRY; end
            end
         end
`ifdef AMOUNT_ENTRY_TIMEOUT_EN
         if ((old_ph == PH_ENTRY || old_ph == PH_LOCK) && !any_ev && m_ph == old_ph) begin
            if (m_quiet == TB_TO - 1) begin
               m_ph = PH_IDLE; m_amt = 0; m_cnt = 0; m_to = 1; m_quiet = 0;
            end else m_quiet++;
         end else m_quiet = 0;
`endif
      end
   end

   task automatic cmp(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         cmp("amount_bin",   int'(bus.amount_bin), m_amt);
         cmp("amount_bcd",   int'(bus.amount_bcd), (m_amt / 10) * 16 + (m_amt % 10));
         cmp("digit_cnt",    int'(bus.digit_cnt), m_cnt);
         cmp("amount_valid", int'(bus.amount_valid), (m_ph == PH_LOCK || m_ph == PH_CHG) ? 1 : 0);
         cmp("start_req",    int'(bus.start_req), int'(m_req));
         cmp("entry_err",    int'(bus.entry_err), int'(m_err));
         cmp("timeout",      int'(bus.timeout), int'(m_to));
         if (bus.start_req) n_req++;
         if (bus.entry_err) n_err++;
         if (bus.timeout)   n_to++;
      end
   end

   task automatic digit(input int d);
      @(negedge clk); bus.key_value = 4'(d); bus.press_num = 1'b1;
      @(negedge clk); bus.press_num = 1'b0;
      @(negedge clk);
   endtask

   // k: 0 = start, 1 = clear, 2 = confirm
   task automatic key(input int k);
      @(negedge clk);
      if (k == 0) bus.start = 1'b1; else if (k == 1) bus.clear = 1'b1; else bus.confirm = 1'b1;
      @(negedge clk); bus.start = 1'b0; bus.clear = 1'b0; bus.confirm = 1'b0;
      @(negedge clk);
   endtask

   initial begin : stim
      int e0, r0, t0;
      rst_n = 1'b1;
      bus.key_value = 4'd5; bus.press_num = 1'b1; bus.confirm = 1'b1;
      bus.start = 1'b0; bus.clear = 1'b0; bus.charge_done = 1'b0;
      repeat (3) @(negedge clk);
      checking = 1'b1;
      cmp("lit_rst_amount", int'(bus.amount_bin), 0);
      cmp("lit_rst_valid",  int'(bus.amount_valid), 0);
      rst_n = 1'b0;
      @(negedge clk);
      cmp("lit_held_reset_amount", int'(bus.amount_bin), 0);
      cmp("lit_held_reset_err",    n_err, 0);
      bus.press_num = 1'b0; bus.confirm = 1'b0;
      @(negedge clk);

      // two-digit entry and charge
      digit(1); digit(5); key(2); key(0);
      cmp("lit_amt15",   int'(bus.amount_bin), 15);
      cmp("lit_bcd15",   int'(bus.amount_bcd), 'h15);
      cmp("lit_valid15", int'(bus.amount_valid), 1);
      cmp("lit_req_once", n_req, 1);
      e0 = n_err;
      key(1);
      cmp("lit_chg_clear_amt", int'(bus.amount_bin), 15);
      cmp("lit_chg_clear_err", n_err - e0, 0);
      @(negedge clk);
      bus.key_value = 4'd3; bus.press_num = 1'b1; bus.charge_done = 1'b1;
      @(negedge clk); bus.press_num = 1'b0; bus.charge_done = 1'b0;
      @(negedge clk);
      cmp("lit_done_amt",   int'(bus.amount_bin), 0);
      cmp("lit_done_valid", int'(bus.amount_valid), 0);

      // over-limit and digit-limit rejection
      e0 = n_err;
      digit(2); digit(5);
      cmp("lit_over_err", n_err - e0, 1);
      cmp("lit_over_amt", int'(bus.amount_bin), 2);
      digit(0);
      cmp("lit_amt20", int'(bus.amount_bin), 20);
      cmp("lit_bcd20", int'(bus.amount_bcd), 'h20);
      digit(1);
      cmp("lit_maxdig_err", n_err - e0, 2);
      cmp("lit_maxdig_amt", int'(bus.amount_bin), 20);
      key(1);

      // leading zeros, clear in LOCKED, confirm in IDLE
      e0 = n_err;
      digit(0); digit(0); digit(7);
      cmp("lit_lz_amt", int'(bus.amount_bin), 7);
      cmp("lit_lz_cnt", int'(bus.digit_cnt), 1);
      cmp("lit_lz_err", n_err - e0, 0);
      key(2); key(1);
      cmp("lit_lock_clear_amt", int'(bus.amount_bin), 0);
      key(2);
      cmp("lit_idle_cfm_err",   n_err - e0, 1);
      cmp("lit_idle_cfm_valid", int'(bus.amount_valid), 0);

      // held number key
      @(negedge clk); bus.key_value = 4'd3; bus.press_num = 1'b1;
      repeat (40) @(negedge clk);
      bus.press_num = 1'b0;
      @(negedge clk);
      cmp("lit_held_amt", int'(bus.amount_bin), 3);
      cmp("lit_held_cnt", int'(bus.digit_cnt), 1);
      key(1);

      // confirm beats start in the same cycle
      r0 = n_req; e0 = n_err;
      digit(4);
      @(negedge clk); bus.confirm = 1'b1; bus.start = 1'b1;
      @(negedge clk); bus.confirm = 1'b0; bus.start = 1'b0;
      @(negedge clk);
      cmp("lit_prio_req",   n_req - r0, 0);
      cmp("lit_prio_err",   n_err - e0, 0);
      cmp("lit_prio_valid", int'(bus.amount_valid), 1);
      key(0);
      cmp("lit_prio_req2", n_req - r0, 1);
      @(negedge clk); bus.charge_done = 1'b1;
      @(negedge clk); bus.charge_done = 1'b0;
      @(negedge clk);

      // idle timeout
      t0 = n_to;
      digit(4);
      repeat (60) @(negedge clk);
`ifdef AMOUNT_ENTRY_TIMEOUT_EN
      cmp("lit_to_amt",   int'(bus.amount_bin), 0);
      cmp("lit_to_count", n_to - t0, 1);
`else
      cmp("lit_to_amt",   int'(bus.amount_bin), 4);
      cmp("lit_to_count", n_to - t0, 0);
`endif
      key(1);

      // reset during charging
      digit(9); key(2); key(0);
      cmp("lit_chg9_valid", int'(bus.amount_valid), 1);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      cmp("lit_midrst_amt",   int'(bus.amount_bin), 0);
      cmp("lit_midrst_valid", int'(bus.amount_valid), 0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/amount_entry_manager.md
# amount_entry_manager

Consumes the debounced key events from the keyboard scanner (digit value, number/START/CLEAR/CONFIRM levels) and turns them into a validated charge amount. It hands that amount and a one-cycle start request to the charge controller. It sits between the keyboard scanner and the charge controller and runs on the same reduced 1000 Hz clock.

## Interface
- MAX_DIGITS, 2, maximum number of significant digits accepted.
- MAX_AMOUNT, 20, largest accepted amount in yuan; must be ≤ 99.
- TIMEOUT_CYC, 10000, idle cycles before auto-clear (10 s at 1 kHz); used only with the timeout feature.
- clk  in  1  reduced system clock, 1000 Hz.
- rst_n  in  1  reset; synchronous, active-high despite the name.
- key_value  in  4  digit from the scanner, valid while press_num is high.
- press_num  in  1  level, high while a number key is held.
- start  in  1  level, START key held.
- clear  in  1  level, CLEAR key held.
- confirm  in  1  level, CONFIRM key held.
- charge_done  in  1  one-cycle pulse from the charge controller when charging ends.
- amount_bin  out  7  current amount, binary.
- amount_bcd  out  8  current amount as {tens, ones} BCD, for the display.
- digit_cnt  out  2  significant digits entered.
- amount_valid  out  1  high in LOCKED and CHARGING.
- start_req  out  1  one-cycle pulse to the charge controller.
- entry_err  out  1  one-cycle pulse on a rejected key.
- timeout  out  1  one-cycle pulse on auto-clear; tied to 0 when the feature is absent.

## Operation
- **Edge detection:** each level input (press_num, start, clear, confirm) is registered. An event is the current input high with the registered copy low.
  - The registered copies reset to 1, so a key held across reset release produces no event.
  - A key held down produces exactly one event.
- **States:** IDLE, ENTRY, LOCKED, CHARGING.
- **Priority of simultaneous events:** clear > confirm > start > digit. Only the highest-priority event is acted on.
- **IDLE** (amount 0, digit_cnt 0):
  - Digit 0 is a leading zero: it is ignored and produces no error.
  - Digit 1–9 loads the amount and sets digit_cnt to 1, then moves to ENTRY. If the digit exceeds MAX_AMOUNT, it is rejected, entry_err pulses, and the state stays IDLE.
  - Confirm or start: entry_err pulses.
  - Clear: no effect.
- **ENTRY:**
  - Digit d: new = amount×10 + d. The product is computed in 8 bits.
  - If digit_cnt == MAX_DIGITS or new > MAX_AMOUNT, the digit is rejected and entry_err pulses. The amount and digit_cnt are unchanged.
  - Otherwise amount takes the new value and digit_cnt increments.
  - Confirm goes to LOCKED.
  - Clear goes to IDLE (amount 0).
  - Start: entry_err pulses.
- **LOCKED:**
  - Start: start_req pulses and the state moves to CHARGING.
  - Clear goes to IDLE.
  - Digit or confirm: entry_err pulses.
- **CHARGING:**
  - The amount is frozen.
  - All key events are ignored, including clear, and produce no error.
  - charge_done goes to IDLE.
  - charge_done in any other state is ignored.
- **Outputs:** amount_bcd is derived from amount_bin (tens = amount/10, ones = amount mod 10). It is registered alongside amount_bin.

## Timing
- **Reset:** on the first rising edge with rst_n high, the state becomes IDLE. All outputs become 0. Edge registers become 1. The timeout counter becomes 0. Reset mid-charge aborts without a start_req.
- **Latency:** an input first sampled high at edge N updates state and outputs at edge N. All pulses are exactly one cycle wide.
- start_req is never asserted in the same cycle as entry_err.
- **charge_done with a simultaneous key event:** charge_done wins and the key event is dropped.

## Configuration
- **AMOUNT_ENTRY_TIMEOUT_EN defined:**
  - A counter runs in ENTRY and LOCKED.
  - It resets to 0 on any key event, on a state change, and in IDLE and CHARGING.
  - When it reaches TIMEOUT_CYC−1, the next edge returns the block to IDLE, clears the amount, and pulses timeout.
  - A key event in that same cycle takes priority and restarts the count.
- **Not defined:**
  - No counter is built and timeout is constant 0.
  - ENTRY and LOCKED persist indefinitely.

## Structure
- **Shared package** (charger_pkg) holds:
  - The state enum (IDLE/ENTRY/LOCKED/CHARGING).
  - Key code constants for digits 0–9.
  - The MAX_AMOUNT default, shared with the charge controller.
- **Sub-module:** key_edge_detect, a 4-bit rising-edge detector with reset value 1, instantiated once for the four level inputs.

## Test plan
- **Two-digit entry:** reset, then digits 1, 5, confirm, start → amount_bin=15, amount_bcd=8'h15, amount_valid=1, and start_req pulses once for one cycle.
- **Over-limit rejection:** 2, 5 → the 5 is rejected and entry_err pulses; amount_bin stays 2. Then 0 → 20 is accepted. A further 1 → entry_err pulses (digit limit).
- **Leading zero and error cases:**
  - 0, 0, 7 → amount 7, digit_cnt=1.
  - Confirm in IDLE → entry_err pulses and the state stays IDLE.
- **Held key:** press_num held high for 40 cycles with key_value 3 → exactly one digit accepted, amount 3.
- **Clear and charging:**
  - Clear in LOCKED → IDLE, amount 0.
  - In CHARGING, clear is ignored.
  - charge_done → IDLE, amount_valid=0.
- **Timeout (macro defined, TIMEOUT_CYC=50):** digit 4, then no keys → timeout pulses 50 cycles later and the amount returns to 0. Without the macro, the amount stays 4.
